// File: rtl/exec_stage_unit.sv
// -----------------------------------------------------------------------------
// exec_stage_unit
// Execute stage behind the decode/execute pipeline register. It runs the ALU,
// keeps the {C,N,Z} flags, and executes shifts one bit per cycle. While a shift
// is running it stalls decode. Results go to the execute/memory register as a
// registered bundle qualified by out_valid.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   flush                    kills the in-flight op; flags are kept
//   in_valid                 decode/execute bundle valid
//   Imm_value_execute        immediate operand
//   shmnt_execute            shift amount
//   Rs_data_execute          source operand
//   Rd_data_execute          destination operand (ALU operand A)
//   Rd_execute               destination register index
//   control_signals_execute  [0]reg_write [1]mem_read [2]mem_write
//                            [3]use_imm   [7:4]alu_op
//   stall                    decode must hold its bundle (shift in flight)
//   out_valid                result bundle valid for one cycle
//   result_mem               ALU / shift result
//   Rd_data_mem, Rd_mem      Rd operand and index, passed through
//   control_mem              control bits [3:0], passed through
//   flags                    {C,N,Z}
// -----------------------------------------------------------------------------
module exec_stage_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Imm_value_execute,
  input  logic [SHW-1:0]   shmnt_execute,
  input  logic [WIDTH-1:0] Rs_data_execute,
  input  logic [WIDTH-1:0] Rd_data_execute,
  input  logic [2:0]       Rd_execute,
  input  logic [7:0]       control_signals_execute,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_mem,
  output logic [WIDTH-1:0] Rd_data_mem,
  output logic [2:0]       Rd_mem,
  output logic [3:0]       control_mem,
  output logic [2:0]       flags
);

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_DEC = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_LDM = 4'd11;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state, state_next;

  logic [3:0]       alu_op;
  logic             use_imm;
  logic [WIDTH-1:0] op_b;
  logic             is_shift;
  logic             accept;

  assign alu_op   = control_signals_execute[7:4];
  assign use_imm  = control_signals_execute[3];
  assign op_b     = use_imm ? Imm_value_execute : Rs_data_execute;
  assign is_shift = (alu_op == OP_SHL) || (alu_op == OP_SHR);
  // Flush outranks acceptance: a bundle presented alongside a flush is dropped.
  assign accept   = (state == IDLE) && in_valid && !flush;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH:0]   wide;
  logic             alu_c;
  logic             upd_zn;
  logic             upd_c;
  logic [2:0]       alu_flags;

  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    alu_result = '0;
    wide       = '0;
    alu_c      = flags[2];
    upd_zn     = 1'b0;
    upd_c      = 1'b0;
    case (alu_op)
      OP_MOV: alu_result = op_b;
      OP_ADD: begin
        wide       = {1'b0, Rd_data_execute} + {1'b0, op_b};
        alu_result = wide[WIDTH-1:0];
        alu_c      = wide[WIDTH];
        upd_zn     = 1'b1;
        upd_c      = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        wide       = {1'b0, Rd_data_execute} - {1'b0, op_b};
        alu_result = wide[WIDTH-1:0];
        alu_c      = wide[WIDTH];
        upd_zn     = 1'b1;
        upd_c      = 1'b1;
      end
      OP_AND: begin alu_result = Rd_data_execute & op_b; upd_zn = 1'b1; end
      OP_OR:  begin alu_result = Rd_data_execute | op_b; upd_zn = 1'b1; end
      OP_NOT: begin alu_result = ~Rd_data_execute;       upd_zn = 1'b1; end
      OP_INC: begin
        wide       = {1'b0, Rd_data_execute} + (WIDTH+1)'(1);
        alu_result = wide[WIDTH-1:0];
        alu_c      = wide[WIDTH];
        upd_zn     = 1'b1;
        upd_c      = 1'b1;
      end
      OP_DEC: begin
        wide       = {1'b0, Rd_data_execute} - (WIDTH+1)'(1);
        alu_result = wide[WIDTH-1:0];
        alu_c      = wide[WIDTH];
        upd_zn     = 1'b1;
        upd_c      = 1'b1;
      end
      OP_LDM:  alu_result = Imm_value_execute;
      default: alu_result = '0;  // NOP and unused encodings
    endcase
  end

  assign alu_flags = {upd_c  ? alu_c                   : flags[2],
                      upd_zn ? alu_result[WIDTH-1]     : flags[1],
                      upd_zn ? (alu_result == '0)      : flags[0]};

  // ---------------------------------------------------------------------------
  // Iterative shifter: one bit per cycle. The carry is collected in shift_c and
  // only committed to flags on completion, so a flushed shift leaves the flags
  // exactly as they were before it started.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [SHW-1:0]   cnt;
  logic             shift_left;
  logic             shift_c;
  logic             step_bit;

  always_comb begin
    if (shift_left) begin
      acc_step = {acc[WIDTH-2:0], 1'b0};
      step_bit = acc[WIDTH-1];
    end else begin
      acc_step = {1'b0, acc[WIDTH-1:1]};
      step_bit = acc[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = (state == SHIFT);
    case (state)
      IDLE:    if (accept && is_shift) state_next = SHIFT;
      SHIFT:   if (flush || (cnt == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result_mem  <= '0;
      Rd_data_mem <= '0;
      Rd_mem      <= '0;
      control_mem <= '0;
      flags       <= '0;
      acc         <= '0;
      cnt         <= '0;
      shift_left  <= 1'b0;
      shift_c     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        Rd_data_mem <= Rd_data_execute;
        Rd_mem      <= Rd_execute;
        control_mem <= control_signals_execute[3:0];
        if (is_shift) begin
          acc        <= Rd_data_execute;
          cnt        <= shmnt_execute;
          shift_left <= (alu_op == OP_SHL);
          shift_c    <= flags[2];  // shmnt=0 must leave C unchanged
          out_valid  <= 1'b0;
        end else begin
          result_mem <= alu_result;
          flags      <= alu_flags;
          out_valid  <= 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      if (cnt != '0) begin
        acc       <= acc_step;
        shift_c   <= step_bit;
        cnt       <= cnt - 1'b1;
        out_valid <= 1'b0;
      end else begin
        result_mem <= acc;
        flags      <= {shift_c, acc[WIDTH-1], (acc == '0)};
        out_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_stage_unit
// Self-checking bench for exec_stage_unit: a hand-derived vector table for the
// single-cycle ops (applied back to back), hand-written shift / flush / reset
// sequences, and a randomized run scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_exec_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] Imm_value_execute;
  logic [4:0]  shmnt_execute;
  logic [15:0] Rs_data_execute;
  logic [15:0] Rd_data_execute;
  logic [2:0]  Rd_execute;
  logic [7:0]  control_signals_execute;
  logic        stall;
  logic        out_valid;
  logic [15:0] result_mem;
  logic [15:0] Rd_data_mem;
  logic [2:0]  Rd_mem;
  logic [3:0]  control_mem;
  logic [2:0]  flags;

  int tests = 0;
  int fails = 0;

  exec_stage_unit #(.WIDTH(16), .SHW(5)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .in_valid                (in_valid),
    .Imm_value_execute       (Imm_value_execute),
    .shmnt_execute           (shmnt_execute),
    .Rs_data_execute         (Rs_data_execute),
    .Rd_data_execute         (Rd_data_execute),
    .Rd_execute              (Rd_execute),
    .control_signals_execute (control_signals_execute),
    .stall                   (stall),
    .out_valid               (out_valid),
    .result_mem              (result_mem),
    .Rd_data_mem             (Rd_data_mem),
    .Rd_mem                  (Rd_mem),
    .control_mem             (control_mem),
    .flags                   (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic        ui;
    logic [15:0] rd;
    logic [15:0] rs;
    logic [15:0] imm;
    logic [2:0]  idx;
    logic [2:0]  lo;
    logic [15:0] exp_res;
    logic [2:0]  exp_fl;   // {C,N,Z}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic ui, input logic [15:0] rd,
                       input logic [15:0] rs, input logic [15:0] imm, input logic [4:0] shm,
                       input logic [2:0] idx, input logic [2:0] lo);
    in_valid                = 1'b1;
    Rd_data_execute         = rd;
    Rs_data_execute         = rs;
    Imm_value_execute       = imm;
    shmnt_execute           = shm;
    Rd_execute              = idx;
    control_signals_execute = {op, ui, lo};
  endtask

  // Counts the cycles stall stays high, bounded so a stuck DUT cannot hang.
  task automatic wait_shift(output int n);
    n = 0;
    while (stall && n < 64) begin
      n++;
      tick();
    end
  endtask

  // One shift from acceptance to completion, checking stall length and result.
  task automatic do_shift(input string name, input logic [3:0] op, input logic [15:0] rd,
                          input logic [4:0] shm, input logic [15:0] exp_res,
                          input logic [2:0] exp_fl);
    int n;
    drive(op, 1'b0, rd, 16'h0, 16'h0, shm, 3'd5, 3'b001);
    tick();
    in_valid = 1'b0;
    check({name, "_valid_low"}, 32'(out_valid), 32'd0);
    wait_shift(n);
    check({name, "_stall_cycles"}, 32'(n), 32'(shm) + 32'd1);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, 32'(result_mem), 32'(exp_res));
    check({name, "_flags"}, 32'(flags), 32'(exp_fl));
    check({name, "_rd_mem"}, 32'(Rd_mem), 32'd5);
    tick();
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic single_op(input string name, input logic [3:0] op, input logic [15:0] rd,
                           input logic [15:0] rs, input logic [15:0] exp_res,
                           input logic [2:0] exp_fl);
    drive(op, 1'b0, rd, rs, 16'h0, 5'd0, 3'd1, 3'b001);
    tick();
    in_valid = 1'b0;
    check({name, "_result"}, 32'(result_mem), 32'(exp_res));
    check({name, "_flags"}, 32'(flags), 32'(exp_fl));
    check({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Reference model: the op table evaluated directly with integer arithmetic.
  // Shifts are computed in one step; the carry is the last bit pushed out.
  function automatic void ref_model(input logic [3:0] op, input logic [15:0] rd,
                                    input logic [15:0] b, input logic [15:0] imm,
                                    input int shm, input logic [2:0] fin,
                                    output logic [15:0] res, output logic [2:0] fout);
    int unsigned a, bb, r;
    logic c, zn;
    a  = rd;
    bb = b;
    r  = 0;
    c  = fin[2];
    zn = 1'b1;
    case (op)
      4'd1:  begin r = bb; zn = 1'b0; end
      4'd2:  begin r = a + bb; c = r[16]; end
      4'd3:  begin r = a - bb; c = (a < bb); end
      4'd4:  r = a & bb;
      4'd5:  r = a | bb;
      4'd6:  r = ~a;
      4'd7:  begin r = a + 1; c = r[16]; end
      4'd8:  begin r = a - 1; c = (a == 0); end
      4'd9:  begin
        r = (shm >= 16) ? 0 : (a << shm);
        if (shm > 0) c = (shm <= 16) ? a[16-shm] : 1'b0;
      end
      4'd10: begin
        r = a >> shm;
        if (shm > 0) c = (shm <= 16) ? a[shm-1] : 1'b0;
      end
      4'd11: begin r = imm; zn = 1'b0; end
      default: begin r = 0; zn = 1'b0; end
    endcase
    res  = r[15:0];
    fout = zn ? {c, res[15], res == 16'h0} : {c, fin[1:0]};
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic ui, input logic [15:0] rd,
                              input logic [15:0] rs, input logic [15:0] imm,
                              input logic [2:0] idx, input logic [2:0] lo,
                              input logic [15:0] exp_res, input logic [2:0] exp_fl);
    vec_t v;
    v.op = op; v.ui = ui; v.rd = rd; v.rs = rs; v.imm = imm;
    v.idx = idx; v.lo = lo; v.exp_res = exp_res; v.exp_fl = exp_fl;
    return v;
  endfunction

  initial begin
    int n;
    logic [2:0]  m_flags;
    logic [15:0] e_res;
    logic [2:0]  e_fl;

    // Applied back to back; expected flags follow the sequence in order.
    vecs.push_back(mk(4'd2,  1'b0, 16'h0003, 16'h0004, 16'h0000, 3'd1, 3'b001, 16'h0007, 3'b000));
    vecs.push_back(mk(4'd2,  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 3'd2, 3'b001, 16'h0000, 3'b101));
    vecs.push_back(mk(4'd3,  1'b0, 16'h0000, 16'h0001, 16'h0000, 3'd3, 3'b001, 16'hFFFF, 3'b110));
    vecs.push_back(mk(4'd1,  1'b1, 16'h0F0F, 16'h7777, 16'h1234, 3'd4, 3'b001, 16'h1234, 3'b110));
    vecs.push_back(mk(4'd4,  1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 3'd5, 3'b100, 16'h00F0, 3'b100));
    vecs.push_back(mk(4'd5,  1'b0, 16'h8000, 16'h0001, 16'h0000, 3'd6, 3'b010, 16'h8001, 3'b110));
    vecs.push_back(mk(4'd6,  1'b0, 16'hFFFF, 16'h0000, 16'h0000, 3'd7, 3'b001, 16'h0000, 3'b101));
    vecs.push_back(mk(4'd7,  1'b0, 16'hFFFF, 16'h0000, 16'h0000, 3'd0, 3'b001, 16'h0000, 3'b101));
    vecs.push_back(mk(4'd8,  1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd1, 3'b001, 16'hFFFF, 3'b110));
    vecs.push_back(mk(4'd0,  1'b0, 16'h1234, 16'h5678, 16'h0000, 3'd2, 3'b000, 16'h0000, 3'b110));
    vecs.push_back(mk(4'd13, 1'b0, 16'h5555, 16'h5555, 16'h0000, 3'd3, 3'b000, 16'h0000, 3'b110));
    vecs.push_back(mk(4'd8,  1'b0, 16'h0005, 16'h0000, 16'h0000, 3'd4, 3'b001, 16'h0004, 3'b000));
    vecs.push_back(mk(4'd3,  1'b1, 16'h0005, 16'h00FF, 16'h0003, 3'd5, 3'b001, 16'h0002, 3'b000));
    vecs.push_back(mk(4'd11, 1'b0, 16'h1111, 16'h2222, 16'hABCD, 3'd6, 3'b001, 16'hABCD, 3'b000));
    vecs.push_back(mk(4'd2,  1'b0, 16'h7FFF, 16'h0001, 16'h0000, 3'd7, 3'b001, 16'h8000, 3'b010));

    // Reset for two cycles with a valid bundle present: reset must win.
    rst = 1'b1;
    flush = 1'b0;
    drive(4'd2, 1'b1, 16'hAAAA, 16'h5555, 16'h1111, 5'd3, 3'd7, 3'b111);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result_mem), 32'd0);
    check("rst_rd_data", 32'(Rd_data_mem), 32'd0);
    check("rst_rd_mem", 32'(Rd_mem), 32'd0);
    check("rst_control", 32'(control_mem), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;

    // Vector table, in_valid held high throughout.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].ui, vecs[i].rd, vecs[i].rs, vecs[i].imm, 5'd0,
            vecs[i].idx, vecs[i].lo);
      tick();
      check($sformatf("vec%0d_result", i), 32'(result_mem), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_fl));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      check($sformatf("vec%0d_rd_data", i), 32'(Rd_data_mem), 32'(vecs[i].rd));
      check($sformatf("vec%0d_rd_mem", i), 32'(Rd_mem), 32'(vecs[i].idx));
      check($sformatf("vec%0d_control", i), 32'(control_mem), 32'({vecs[i].ui, vecs[i].lo}));
    end
    in_valid = 1'b0;
    tick();
    check("idle_valid_low", 32'(out_valid), 32'd0);

    // Shifts; flags enter as 010 from the last vector.
    do_shift("shl3",  4'd9,  16'h8001, 5'd3,  16'h0008, 3'b000);
    do_shift("shr1",  4'd10, 16'h0001, 5'd1,  16'h0000, 3'b101);
    do_shift("shl0",  4'd9,  16'h1234, 5'd0,  16'h1234, 3'b100);
    do_shift("shl16", 4'd9,  16'h0001, 5'd16, 16'h0000, 3'b101);
    do_shift("shr20", 4'd10, 16'hFFFF, 5'd20, 16'h0000, 3'b001);

    // Flush in shift cycle 3 with a bundle presented alongside it.
    single_op("pre_flush", 4'd2, 16'hFFFF, 16'h0001, 16'h0000, 3'b101);
    drive(4'd9, 1'b0, 16'h8000, 16'h0000, 16'h0000, 5'd10, 3'd2, 3'b001);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("flush_stall_before", 32'(stall), 32'd1);
    flush = 1'b1;
    drive(4'd2, 1'b0, 16'h0002, 16'h0003, 16'h0000, 5'd0, 3'd3, 3'b001);
    tick();
    flush = 1'b0;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_flags", 32'(flags), 32'b101);
    tick();
    in_valid = 1'b0;
    check("post_flush_valid", 32'(out_valid), 32'd1);
    check("post_flush_result", 32'(result_mem), 32'h0005);
    check("post_flush_flags", 32'(flags), 32'b000);
    check("post_flush_rd_mem", 32'(Rd_mem), 32'd3);

    // Reset in the middle of a shift.
    single_op("pre_rst", 4'd2, 16'hFFFF, 16'h0001, 16'h0000, 3'b101);
    drive(4'd9, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 5'd8, 3'd6, 3'b001);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_result", 32'(result_mem), 32'd0);
    check("midrst_rd_mem", 32'(Rd_mem), 32'd0);

    // Randomized run against the reference model, starting from reset flags.
    m_flags = 3'b000;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic        ui;
      logic [15:0] rd, rs, imm;
      logic [4:0]  shm;
      logic [2:0]  idx;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
        check($sformatf("rand%0d_gap_valid", i), 32'(out_valid), 32'd0);
      end
      op  = 4'($urandom_range(0, 15));
      ui  = 1'($urandom());
      rd  = 16'($urandom());
      rs  = 16'($urandom());
      imm = 16'($urandom());
      idx = 3'($urandom());
      shm = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(14, 19)) : 5'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) rd = 16'h0000;
      if ($urandom_range(0, 7) == 0) rd = 16'hFFFF;
      ref_model(op, rd, ui ? imm : rs, imm, int'(shm), m_flags, e_res, e_fl);
      drive(op, ui, rd, rs, imm, shm, idx, 3'b001);
      tick();
      if (op == 4'd9 || op == 4'd10) begin
        in_valid = 1'b0;
        wait_shift(n);
        check($sformatf("rand%0d_stall_cycles", i), 32'(n), 32'(shm) + 32'd1);
      end else begin
        check($sformatf("rand%0d_stall", i), 32'(stall), 32'd0);
      end
      check($sformatf("rand%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("rand%0d_result op=%0d", i, op), 32'(result_mem), 32'(e_res));
      check($sformatf("rand%0d_flags op=%0d", i, op), 32'(flags), 32'(e_fl));
      check($sformatf("rand%0d_rd_data", i), 32'(Rd_data_mem), 32'(rd));
      m_flags = e_fl;
    end
    in_valid = 1'b0;
    tick();
    check("final_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_stage_unit.md
Name: exec_stage_unit

Overview:
Execute-stage consumer of the decode/execute pipeline register outputs (immediate, shift amount, Rs/Rd data, destination register, 8-bit control bundle).
- Performs the ALU operation and maintains the Z/N/C flags.
- Runs shifts iteratively, one bit per cycle, and holds decode off with a stall while a shift is in flight.
- Presents a registered result bundle with a valid flag to the execute/memory register.

Parameters:
WIDTH, 16, datapath width
SHW, 5, shift-amount width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous kill of the in-flight op (branch/hazard unit)
in_valid  input  1  decode/execute bundle is valid
Imm_value_execute  input  WIDTH  immediate
shmnt_execute  input  SHW  shift amount
Rs_data_execute  input  WIDTH  source operand
Rd_data_execute  input  WIDTH  destination operand
Rd_execute  input  3  destination register index
control_signals_execute  input  8  [0]reg_write [1]mem_read [2]mem_write [3]use_imm [7:4]alu_op
stall  output  1  decode must hold its bundle; combinational, equals (state==SHIFT)
out_valid  output  1  result bundle valid for exactly one cycle
result_mem  output  WIDTH  ALU result
Rd_data_mem  output  WIDTH  Rd operand passed through (store data)
Rd_mem  output  3  destination index passed through
control_mem  output  4  control bits [3:0] passed through
flags  output  3  {C,N,Z}

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; out_valid, result_mem, Rd_data_mem, Rd_mem, control_mem and flags all 0. Priority: rst > flush > normal operation.
- States: IDLE and SHIFT.
- Accept rule: a bundle is accepted on a posedge where state==IDLE and in_valid=1. With in_valid=0 in IDLE, out_valid goes to 0 at the next posedge.
- Operand B = use_imm ? Imm_value_execute : Rs_data_execute.
- alu_op encoding:
  - 0 NOP: result=0, flags held
  - 1 MOV: result=B
  - 2 ADD: Rd+B, C=carry-out
  - 3 SUB: Rd-B, C=borrow
  - 4 AND: Rd&B
  - 5 OR: Rd|B
  - 6 NOT: ~Rd
  - 7 INC: Rd+1, C=carry
  - 8 DEC: Rd-1, C=borrow
  - 9 SHL: Rd << shmnt
  - 10 SHR: Rd >> shmnt (logical)
  - 11 LDM: result=Imm
  - 12-15: treated as NOP
- Single-cycle ops (every op except 9 and 10):
  - Result registered at the accept edge; out_valid=1 for the following cycle. Latency 1.
  - Back-to-back acceptance every cycle.
- Z and N update from the result on ops 2-8. C updates only on ops 2, 3, 7, 8. Ops 1 and 11 do not touch flags.
- Shift ops:
  - Accept edge: acc←Rd, cnt←shmnt, state←SHIFT, out_valid←0.
  - Each SHIFT posedge with cnt≠0: acc shifts 1 bit, C←bit shifted out, cnt−1.
  - SHIFT posedge with cnt==0: result_mem←acc, out_valid←1, Z/N from acc, state←IDLE.
  - Latency shmnt+1 cycles; stall high for shmnt+1 cycles.
  - shmnt=0 gives result=Rd, C unchanged.
  - shmnt≥16 gives result 0, with C = last bit shifted out (C=0 when shmnt>16).
- Pass-through fields (Rd_data_mem, Rd_mem, control_mem) are captured at the accept edge and held unchanged until the next accept.
- Flush at posedge:
  - state←IDLE, out_valid←0, partial shift discarded, flags keep their prior value.
  - A bundle presented in the same cycle is not accepted.
- Reset mid-shift has the same effect as reset; flags cleared.
- Inputs are ignored while state==SHIFT; the upstream holds them under stall.

Test Plan:
- Reset: assert rst for 2 cycles → all outputs 0, stall=0; release; ADD with Rd=0x0003, Rs=0x0004 → next cycle result_mem=0x0007, out_valid=1, flags=000.
- Carry/zero: ADD 0xFFFF+0x0001 → result 0x0000, flags {C=1,N=0,Z=1}. Then SUB 0x0000−0x0001 → 0xFFFF, {C=1,N=1,Z=0}.
- Immediate: use_imm=1, Imm=0x1234, alu_op=1 → result 0x1234, flags unchanged from the previous value.
- Shift: SHL Rd=0x8001, shmnt=3 → stall high 4 cycles; out_valid in cycle 4 with result 0x0008, C=0. SHR Rd=0x0001, shmnt=1 → result 0x0000, C=1, Z=1. shmnt=0 → result=Rd, one stall cycle.
- Flush: start SHL shmnt=10, assert flush in shift cycle 3 → next cycle stall=0, out_valid stays 0, flags equal their pre-shift values; new ADD accepted the following cycle.
- Throughput: 5 consecutive single-cycle ops with in_valid held high → 5 consecutive out_valid cycles, results in order, stall never asserted.
